// File: rtl/caravel.sv
// Two-digit frequency counter: counts rising edges of mprj_io[8] per window
// and shows the saturated count on a multiplexed seven-segment display.
module caravel #(
  parameter int UPDATE_PERIOD = 1200,
  parameter int SAT_MAX       = 99
) (
  input  logic       clock,
  input  logic       reset,
  inout  wire [37:0] mprj_io
);

  localparam int               CNT_BITS = $clog2(SAT_MAX + 1);
  localparam int               EW       = (CNT_BITS < 4) ? 4 : CNT_BITS;
  localparam logic [15:0]      WIN_LAST = 16'(UPDATE_PERIOD - 1);
  localparam logic [EW-1:0]    SAT      = EW'(SAT_MAX);
  localparam logic [EW-1:0]    TEN      = EW'(10);
  localparam logic [EW-1:0]    NINE     = EW'(9);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TENS  = 2'd1,
    UNITS = 2'd2
  } state_t;

  logic          signal;
  logic          sync1;
  logic          sync2;
  logic          sync_prev;
  logic          edge_det;
  logic [15:0]   win_cnt;
  logic          win_end;
  logic [EW-1:0] edge_cnt;
  state_t        state;
  logic [EW-1:0] conv;
  logic [EW-1:0] tens;
  logic [EW-1:0] disp_tens;
  logic [EW-1:0] disp_units;
  logic          digit;
  logic [6:0]    segments;

  assign mprj_io[37:17] = {21{1'bz}};
  assign mprj_io[16]    = digit;
  assign mprj_io[15:9]  = segments;
  assign mprj_io[8:0]   = {9{1'bz}};
  assign signal         = mprj_io[8];

  function automatic logic [6:0] encode(input logic [EW-1:0] v);
    logic [6:0] s;
    s = 7'h00;
    if (v <= NINE) begin
      case (v[3:0])
        4'd0:    s = 7'h3F;
        4'd1:    s = 7'h06;
        4'd2:    s = 7'h5B;
        4'd3:    s = 7'h4F;
        4'd4:    s = 7'h66;
        4'd5:    s = 7'h6D;
        4'd6:    s = 7'h7D;
        4'd7:    s = 7'h07;
        4'd8:    s = 7'h7F;
        4'd9:    s = 7'h6F;
        default: s = 7'h00;
      endcase
    end
    return s;
  endfunction

  // signal is asynchronous; only sync2 onward may be used as logic
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync1     <= signal;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign edge_det = sync2 & ~sync_prev;
  assign win_end  = (win_cnt == WIN_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      win_cnt <= 16'd0;
    end else if (win_end) begin
      win_cnt <= 16'd0;
    end else begin
      win_cnt <= win_cnt + 16'd1;
    end
  end

  // An edge landing on the window-end cycle belongs to the new window
  always_ff @(posedge clock) begin
    if (reset) begin
      edge_cnt <= '0;
    end else if (win_end) begin
      edge_cnt <= edge_det ? EW'(1) : '0;
    end else if (edge_det && (edge_cnt < SAT)) begin
      edge_cnt <= edge_cnt + EW'(1);
    end
  end

  // Repeated subtraction; the remainder goes straight into the display units
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      conv       <= '0;
      tens       <= '0;
      disp_tens  <= '0;
      disp_units <= '0;
    end else if (win_end) begin
      state <= TENS;
      conv  <= edge_cnt;
      tens  <= '0;
    end else begin
      case (state)
        TENS: begin
          if (conv >= TEN) begin
            conv <= conv - TEN;
            tens <= tens + EW'(1);
          end else begin
            state <= UNITS;
          end
        end
        UNITS: begin
          disp_tens  <= tens;
          disp_units <= conv;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      digit    <= 1'b0;
      segments <= 7'h00;
    end else begin
      digit    <= ~digit;
      segments <= encode(~digit ? disp_tens : disp_units);
    end
  end

endmodule

// File: tb/tb_caravel.sv
// tb/tb_caravel.sv - randomized edge-count scenarios checked against a window/edge model
module tb_caravel;

  localparam int P    = 200;
  localparam int SATV = 99;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sig   = 1'b0;
  logic [28:0] hz_pat = '0;
  wire  [37:0] mprj_io;
  wire  [6:0]  seg   = mprj_io[15:9];
  wire         digit = mprj_io[16];

  assign mprj_io[8]     = sig;
  assign mprj_io[37:17] = hz_pat[28:8];
  assign mprj_io[7:0]   = hz_pat[7:0];

  caravel #(.UPDATE_PERIOD(P), .SAT_MAX(SATV)) dut (
    .clock   (clock),
    .reset   (reset),
    .mprj_io (mprj_io)
  );

  always #5 clock = ~clock;

  int   n_cmp = 0;
  int   n_err = 0;
  int   k;
  int   cnt [0:63];
  bit   mask [0:4095];
  int   mode;
  int   per;
  int   phase;
  logic [6:0] enc_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Count shown after posedge kk, or -1 while a conversion may be in flight
  function automatic int shown(input int kk);
    int r, q, w;
    r = kk % P;
    q = kk / P;
    if (r <= 1) w = q - 2;
    else if (r >= 12) w = q - 1;
    else return -1;
    if (w < 0) return 0;
    return (cnt[w] > SATV) ? SATV : cnt[w];
  endfunction

  task automatic cycle();
    int   v, m;
    logic s;
    logic [6:0] e;
    @(negedge clock);
    k++;
    check("digit", {63'd0, digit}, {63'd0, 1'(k % 2)});
    check("hiz", {35'd0, mprj_io[37:17], mprj_io[7:0]}, {35'd0, hz_pat});
    v = shown(k);
    if (v >= 0) begin
      e = enc_tab[(k % 2 == 1) ? v / 10 : v % 10];
      check("segments", {57'd0, seg}, {57'd0, e});
    end
    case (mode)
      1:       s = ((k + phase) % per) < (per / 2);
      2:       s = ($urandom_range(0, 2) == 0) ? ~sig : sig;
      3:       s = (k < 4096) ? mask[k] : 1'b0;
      default: s = 1'b0;
    endcase
    // a rise driven now is first sampled at posedge k+1 and counted at k+3
    if (s && !sig) begin
      m = k + 3;
      if (m / P < 64) cnt[m / P]++;
    end
    sig    = s;
    hz_pat = 29'($urandom);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset(input int n);
    @(negedge clock);
    reset = 1'b1;
    sig   = 1'b0;
    repeat (n) begin
      @(negedge clock);
      check("rst_segments", {57'd0, seg}, 64'd0);
      check("rst_digit", {63'd0, digit}, 64'd0);
    end
    reset = 1'b0;
    k = 0;
    for (int i = 0; i < 64; i++) cnt[i] = 0;
  endtask

  initial begin
    int w, s, picked;
    mode   = 0;
    per    = 4;
    phase  = 0;
    hz_pat = 29'($urandom);
    for (int i = 0; i < 4096; i++) mask[i] = 1'b0;

    do_reset(3);
    run(2 * P);

    mode  = 1;
    per   = 4;
    phase = $urandom_range(0, 3);
    run(2 * P);

    mode = 0;
    run(P);

    w = k / P + 1;
    picked = 0;
    while (picked < 37) begin
      s = $urandom_range(0, 99);
      if (!mask[w * P - 3 + 2 * s]) begin
        mask[w * P - 3 + 2 * s] = 1'b1;
        picked++;
      end
    end
    mode = 3;
    run((w + 1) * P + 20 - k);
    mode = 0;
    run(P);

    mode  = 1;
    per   = 2;
    phase = $urandom_range(0, 1);
    run(2 * P + 20);

    mode = 2;
    run(3 * P);

    mode  = 1;
    per   = $urandom_range(3, 9);
    phase = $urandom_range(0, 8);
    run(2 * P);

    per   = 4;
    phase = 0;
    run(2 * P - (k % P));
    run(3);
    do_reset(2);
    run(3 * P);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
